bit_scan_8: RTL and testbench

Sequential set-bit enumerator for an 8-bit vector: the expanding counterpart to the 8-input OR reduction. The reduction collapses eight lines into one "any set" bit. This block takes an 8-bit request vector and hands out each set bit individually, lowest index first, one per accepted handshake. It sits downstream of request-collection logic and upstream of any consumer that services one request line at a time.

---
 rtl/bit_scan_8.sv | 104 ++++++++++
 tb/tb_bit_scan_8.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bit_scan_8.sv
// bit_scan_8: hands out the set bits of an 8-bit request vector one at a
// time, lowest index first, over a valid/ready handshake.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   load request, honoured only while idle
//   din     request vector captured on an accepted start
//   ready   consumer accepts the current item
//   valid   onehot/index carry a pending item
//   onehot  lowest still-pending set bit (0 when not valid)
//   index   binary position of onehot (0 when not valid)
//   any     OR of the last captured din
//   busy    high while scanning or finishing
//   done    one-cycle pulse closing each scan
module bit_scan_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] onehot,
    output logic [2:0] index,
    output logic       any,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       any_q, any_d;
    logic [7:0] lowest;

    function automatic logic [2:0] enc(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Two's-complement trick isolates the lowest set bit.
    assign lowest = pending_q & (~pending_q + 8'd1);
    assign any    = any_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            any_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            any_q     <= any_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        any_d     = any_q;
        valid     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        onehot    = 8'h00;
        index     = 3'd0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d = din;
                    any_d     = |din;
                    state_d   = (din == 8'h00) ? DONE : SCAN;
                end
            end
            SCAN: begin
                valid  = 1'b1;
                busy   = 1'b1;
                onehot = lowest;
                index  = enc(lowest);
                if (ready) begin
                    pending_d = pending_q & ~lowest;
                    if (pending_d == 8'h00) state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_scan_8.sv
// Self-checking bench for bit_scan_8: directed and random request vectors
// compared against a queue-based model of the expected item order.
module tb_bit_scan_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       valid;
    logic [7:0] onehot;
    logic [2:0] index;
    logic       any;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    bit_scan_8 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .ready  (ready),
        .valid  (valid),
        .onehot (onehot),
        .index  (index),
        .any    (any),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_any);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".onehot"}, 32'(onehot), 0);
        chk({tag, ".index"}, 32'(index), 0);
        chk({tag, ".any"}, 32'(any), 32'(exp_any));
    endtask

    // mode 0: ready always 1; 1: toggle 1,0,1,0..; 2: random ready.
    // Called and returns at a negedge with the block idle.
    task automatic run_scan(input logic [7:0] d, input int mode,
                            input bit inject);
        int  q[$];
        int  n;
        int  accepts;
        bit  r;
        bit  tog;
        bit  fin;
        logic exp_any;
        accepts = 0;
        tog     = 1'b1;
        fin     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) q.push_back(i);
        end
        n       = q.size();
        exp_any = (n != 0);
        start   = 1'b1;
        din     = d;
        ready   = 1'($urandom % 2);
        @(negedge clk);
        start = 1'b0;
        din   = 8'($urandom);
        for (int c = 0; c < 64 && !fin; c++) begin
            if (q.size() > 0) begin
                chk("scan.valid", 32'(valid), 1);
                chk("scan.index", 32'(index), 32'(q[0]));
                chk("scan.onehot", 32'(onehot), 32'(1) << q[0]);
                chk("scan.busy", 32'(busy), 1);
                chk("scan.done", 32'(done), 0);
                chk("scan.any", 32'(any), 32'(exp_any));
                if (mode == 0) r = 1'b1;
                else if (mode == 1) r = tog;
                else r = 1'($urandom % 2);
                tog   = ~tog;
                ready = r;
                if (r) begin
                    void'(q.pop_front());
                    accepts++;
                end
                if (inject && c == 0) begin
                    start = 1'b1;
                    din   = 8'h7E;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end else begin
                start = 1'b0;
                chk("done.done", 32'(done), 1);
                chk("done.valid", 32'(valid), 0);
                chk("done.busy", 32'(busy), 1);
                chk("done.onehot", 32'(onehot), 0);
                chk("done.index", 32'(index), 0);
                chk("done.any", 32'(any), 32'(exp_any));
                chk("accept_count", 32'(accepts), 32'(n));
                ready = 1'($urandom % 2);
                @(negedge clk);
                chk_idle("after_done", exp_any);
                fin = 1'b1;
            end
        end
        if (!fin) chk("scan_timeout", 0, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        ready = 1'b0;
        #1;
        chk_idle("reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset", 1'b0);

        // Sparse vector with ready held high.
        run_scan(8'b1010_0100, 0, 1'b0);
        // Empty vector.
        run_scan(8'h00, 2, 1'b0);
        // Full vector with alternating backpressure.
        run_scan(8'hFF, 1, 1'b0);
        // start while busy is ignored, then the new vector is scanned.
        run_scan(8'h81, 0, 1'b1);
        run_scan(8'h7E, 0, 1'b0);

        // Asynchronous reset mid-scan.
        start = 1'b1;
        din   = 8'hA5;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst.valid", 32'(valid), 1);
        chk("pre_rst.index", 32'(index), 0);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst", 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("rst_idle", 1'b0);
        end

        // rst wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle("rst_vs_start", 1'b0);

        // Random vectors with random backpressure.
        for (int t = 0; t < 40; t++) begin
            run_scan(8'($urandom), 2, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
